// File: rtl/shift_pipe.sv
// Pipelined log-shifter (ROR/ROL/SLL/SRA). One stage per shift-amount bit.
// The whole pipe advances together and freezes while the output is stalled.
module shift_pipe #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   localparam int NS = SHAMT_W;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_ROL = 2'b01;
   localparam logic [1:0] OP_SLL = 2'b10;

   if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("shift_pipe: WIDTH must be a power of two between 4 and 64");
   end

   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input logic             en,
      input int               amt
   );
      logic [WIDTH-1:0] r;
      r = d;
      if (en) begin
         case (op)
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_SLL:  r = d << amt;
            default: r = $signed(d) >>> amt;
         endcase
      end
      return r;
   endfunction

   logic [WIDTH-1:0]   data_q  [NS];
   logic [WIDTH-1:0]   data_d  [NS];
   logic [SHAMT_W-1:0] shamt_q [NS];
   logic [SHAMT_W-1:0] shamt_d [NS];
   logic [1:0]         op_q    [NS];
   logic [1:0]         op_d    [NS];
   logic [NS-1:0]      valid_q;
   logic [NS-1:0]      valid_d;
   logic               zero_q;
   logic               zero_d;
   logic               stall;

   assign stall    = valid_q[NS-1] & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      data_d  = data_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      valid_d = valid_q;
      zero_d  = zero_q;
      if (!stall) begin
         // Stage k resolves shamt bit k; bubbles move along with valid=0.
         data_d[0]  = stage_shift(in_data, in_op, in_shamt[0], 1);
         shamt_d[0] = in_shamt;
         op_d[0]    = in_op;
         valid_d[0] = in_valid;
         for (int k = 1; k < NS; k++) begin
            data_d[k]  = stage_shift(data_q[k-1], op_q[k-1], shamt_q[k-1][k], 1 << k);
            shamt_d[k] = shamt_q[k-1];
            op_d[k]    = op_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         zero_d = (data_d[NS-1] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NS; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            op_q[k]    <= '0;
         end
         valid_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         shamt_q <= shamt_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
      end
   end

   assign out_valid = valid_q[NS-1];
   assign out_data  = data_q[NS-1];
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH=16): directed vectors, stall,
// reset-in-flight and a random stream against a bitwise reference model.
module tb_shift_pipe;

   localparam int W  = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [SW-1:0] in_shamt = '0;
   logic [1:0]    in_op = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic          out_zero;

   shift_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         zero;
      int           acc;
      bit           chk_lat;
   } exp_t;

   exp_t         sb[$];
   exp_t         e_mon;
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           n_out = 0;
   int           ir_low = 0;
   bit           chk_lat = 1'b1;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic [1:0] op);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (op)
            2'b00:   r[i] = d[(i + s) % W];
            2'b01:   r[(i + s) % W] = d[i];
            2'b10:   r[i] = (i >= s) ? d[i - s] : 1'b0;
            default: r[i] = (i + s < W) ? d[i + s] : d[W-1];
         endcase
      end
      return r;
   endfunction

   // Monitor: pops the scoreboard on every output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_data", {16'd0, out_data}, {16'd0, prev_data});
         end
         if (!in_ready) ir_low++;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stale_out: got 0x%0h, expected no beat", out_data);
            end else begin
               e_mon = sb.pop_front();
               check("out_data", {16'd0, out_data}, {16'd0, e_mon.data});
               check("out_zero", {31'd0, out_zero}, {31'd0, e_mon.zero});
               if (e_mon.chk_lat) check("latency", cyc - e_mon.acc, 32'd4);
               n_out++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s,
                       input logic [1:0] op, input logic [W-1:0] exp_d);
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.data    = exp_d;
            e.zero    = (exp_d == '0);
            e.acc     = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() > 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
      end
   endtask

   typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      logic [1:0]    op;
      logic [W-1:0]  r;
   } vec_t;

   vec_t vecs[14] = '{
      '{16'h8001, 4'd1,  2'b00, 16'hC000},
      '{16'h8001, 4'd4,  2'b01, 16'h0018},
      '{16'hFFFF, 4'd15, 2'b10, 16'h8000},
      '{16'h1234, 4'd0,  2'b10, 16'h1234},
      '{16'h8000, 4'd15, 2'b11, 16'hFFFF},
      '{16'h4000, 4'd15, 2'b11, 16'h0000},
      '{16'h1234, 4'd0,  2'b00, 16'h1234},
      '{16'h1234, 4'd0,  2'b01, 16'h1234},
      '{16'h9234, 4'd0,  2'b11, 16'h9234},
      '{16'h0001, 4'd4,  2'b00, 16'h1000},
      '{16'hF000, 4'd4,  2'b11, 16'hFF00},
      '{16'hABCD, 4'd8,  2'b01, 16'hCDAB},
      '{16'h00F0, 4'd15, 2'b00, 16'h01E0},
      '{16'h7FFF, 4'd1,  2'b11, 16'h3FFF}
   };

   initial begin
      int snap;
      int n_in;
      int cycles;
      logic [W-1:0] v;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_out_zero", {31'd0, out_zero}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vectors, back to back, fixed latency
      chk_lat = 1'b1;
      foreach (vecs[i]) send(vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].r);
      drain();

      // Mid-stream stall of 3 cycles
      chk_lat = 1'b0;
      snap = ir_low;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               v = 16'h0123 + 16'(i);
               send(v, 4'd4, 2'b10, v << 4);
            end
         end
         begin
            for (int t = 0; t < 50; t++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_in_ready_low_cycles", ir_low - snap, 32'd3);

      // Reset with three beats in flight
      chk_lat = 1'b1;
      send(16'h1111, 4'd1, 2'b00, 16'h8888);
      send(16'h2222, 4'd2, 2'b01, 16'h8888);
      send(16'h3333, 4'd3, 2'b10, 16'h9998);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      send(16'h0F00, 4'd4, 2'b01, 16'hF000);
      drain();

      // Random stream
      chk_lat = 1'b0;
      snap    = n_out;
      n_in    = 0;
      cycles  = 0;
      while (n_in < 10000 && cycles < 60000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         in_shamt  = 4'($urandom);
         in_op     = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back('{data: model(in_data, int'(in_shamt), in_op),
                           zero: (model(in_data, int'(in_shamt), in_op) == '0),
                           acc: cyc, chk_lat: 1'b0});
            n_in++;
         end
         @(posedge clk); #1;
         cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (n_in < 10000) begin
         n_cmp++;
         n_err++;
         $display("FAIL random_timeout: got %0d beats accepted, expected 10000", n_in);
      end
      drain();
      check("beats_in_vs_out", n_out - snap, n_in);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
